// File: rtl/secam_pkg.sv
// Shared types and constants for the SECAM chroma line sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package secam_pkg;

    localparam int SecamFilterLatencyDefault = 4;
    localparam int SecamSampleWidth          = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_ARMED  = 3'd2,
        S_ACTIVE = 3'd3,
        S_DRAIN  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Single-bit shift register carrying the feed flag to the output enable.
// Latency: Depth cycles from d to q.
// Backpressure: none; synchronous clr empties every stage in one cycle.
module valid_delay_line #(
    parameter int Depth = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [Depth-1:0] r_shift;

    // Shift the flag one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (clr) begin
            r_shift <= '0;
        end else begin
            r_shift[0] <= d;
            for (int i = 1; i < Depth; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign q = r_shift[Depth-1];

endmodule

// File: rtl/secam_chroma_sequencer.sv
// Per-line Db/Dr sequencer: flushes the chroma filter with zeros, feeds active samples, gates its output.
// Latency: sample -> filt_in 1 cycle; sample -> chroma_out/chroma_en 1+FilterLatency cycles.
// Backpressure: none; line_start preempts any state and discards the old line's tail.
module secam_chroma_sequencer
    import secam_pkg::*;
#(
    parameter int FilterLatency = SecamFilterLatencyDefault,
    parameter int FlushCycles   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               line_start,
    input  logic                               field_start,
    input  logic                               active_video,
    input  logic signed [SecamSampleWidth-1:0] db,
    input  logic signed [SecamSampleWidth-1:0] dr,
    output logic signed [SecamSampleWidth-1:0] filt_in,
    input  logic signed [SecamSampleWidth-1:0] filt_out,
    output logic signed [SecamSampleWidth-1:0] chroma_out,
    output logic                               chroma_en,
    output logic                               is_dr,
    output logic                               osc_phase_reset,
    output logic                               busy
);

    localparam int CntMax = (FlushCycles > FilterLatency) ? FlushCycles : FilterLatency;
    localparam int CntW   = $clog2(CntMax) + 1;
    localparam logic [CntW-1:0] FlushLoad = CntW'(FlushCycles - 1);
    localparam logic [CntW-1:0] DrainLoad = CntW'(FilterLatency - 1);

    seq_state_e                         r_state;
    logic [CntW-1:0]                    r_cnt;
    logic                               r_next_dr;
    logic                               r_is_dr;
    logic                               r_osc;
    logic                               r_fed;
    logic signed [SecamSampleWidth-1:0] r_filt_in;

    logic                               w_feed;
    logic                               w_line_dr;
    logic signed [SecamSampleWidth-1:0] w_sel;

    // Samples are only taken once the filter has been flushed and the line is armed or running.
    assign w_feed    = active_video && ((r_state == S_ARMED) || (r_state == S_ACTIVE));
    assign w_sel     = r_is_dr ? dr : db;
    // A field start forces the new line to Db regardless of the alternation history.
    assign w_line_dr = field_start ? 1'b0 : r_next_dr;

    // Line FSM: line_start wins from any state, then per-state counter walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_next_dr <= 1'b0;
            r_is_dr   <= 1'b0;
            r_osc     <= 1'b0;
        end else begin
            r_osc <= 1'b0;
            if (line_start) begin
                r_state   <= S_FLUSH;
                r_cnt     <= FlushLoad;
                r_is_dr   <= w_line_dr;
                r_next_dr <= ~w_line_dr;
                r_osc     <= 1'b1;
            end else begin
                if (field_start) begin
                    r_next_dr <= 1'b0;
                end
                case (r_state)
                    S_IDLE: begin
                    end
                    S_FLUSH: begin
                        if (r_cnt == '0) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (active_video) begin
                            r_state <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (!active_video) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= DrainLoad;
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Filter input register; r_fed marks a real sample and is suppressed on abort so its result is never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_in <= '0;
            r_fed     <= 1'b0;
        end else begin
            r_filt_in <= w_feed ? w_sel : '0;
            r_fed     <= w_feed && !line_start;
        end
    end

    // r_fed already carries one cycle, so a FilterLatency-deep line lines the enable up with filt_out.
    valid_delay_line #(
        .Depth (FilterLatency)
    ) u_en_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (line_start),
        .d     (r_fed),
        .q     (chroma_en)
    );

    assign filt_in         = r_filt_in;
    assign is_dr           = r_is_dr;
    assign osc_phase_reset = r_osc;
    assign busy            = (r_state != S_IDLE);
    assign chroma_out      = chroma_en ? filt_out : '0;

endmodule

// File: tb/tb_secam_chroma_sequencer.sv
// Directed bench for secam_chroma_sequencer with a pure-delay filter stand-in.
// Latency: filter stand-in delays filt_in by FL cycles.
// Backpressure: n/a.
module tb_secam_chroma_sequencer;

    localparam int FL = 4;
    localparam int FC = 16;

    logic clk          = 1'b0;
    logic rst_n        = 1'b1;
    logic line_start   = 1'b0;
    logic field_start  = 1'b0;
    logic active_video = 1'b0;
    logic signed [8:0] db = '0;
    logic signed [8:0] dr = '0;
    logic signed [8:0] filt_in;
    logic signed [8:0] filt_out;
    logic signed [8:0] chroma_out;
    logic chroma_en;
    logic is_dr;
    logic osc_phase_reset;
    logic busy;

    int checks   = 0;
    int failures = 0;

    logic signed [8:0] exp_q[$];
    logic signed [8:0] filt_pipe[FL];

    always #5 clk = ~clk;

    secam_chroma_sequencer #(
        .FilterLatency (FL),
        .FlushCycles   (FC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .line_start      (line_start),
        .field_start     (field_start),
        .active_video    (active_video),
        .db              (db),
        .dr              (dr),
        .filt_in         (filt_in),
        .filt_out        (filt_out),
        .chroma_out      (chroma_out),
        .chroma_en       (chroma_en),
        .is_dr           (is_dr),
        .osc_phase_reset (osc_phase_reset),
        .busy            (busy)
    );

    // Filter stand-in: identity response with FL cycles of delay.
    initial begin
        for (int i = 0; i < FL; i++) filt_pipe[i] = '0;
    end
    always @(posedge clk) begin
        filt_pipe[0] <= filt_in;
        for (int i = 1; i < FL; i++) filt_pipe[i] <= filt_pipe[i-1];
    end
    assign filt_out = filt_pipe[FL-1];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs for this cycle, then land just after the edge.
    task automatic cyc(input logic ls, input logic fs, input logic av,
                       input logic signed [8:0] b, input logic signed [8:0] r);
        line_start   = ls;
        field_start  = fs;
        active_video = av;
        db           = b;
        dr           = r;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every enabled output must match the next expected sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chroma_en === 1'b1) begin
                if (exp_q.size() == 0) chk("chroma_en_unexpected", 32'(chroma_en), 0);
                else                   chk("chroma_out", 32'(chroma_out), 32'(exp_q.pop_front()));
            end else begin
                chk("chroma_out_gated", 32'(chroma_out), 0);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_is_dr", 32'(is_dr), 0);
        chk("rst_filt_in", 32'(filt_in), 0);
        chk("rst_chroma_en", 32'(chroma_en), 0);
        chk("rst_osc", 32'(osc_phase_reset), 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Line 1 (Db): flush ignores active_video, then a 10-sample burst.
        cyc(1, 0, 0, 0, 0);
        chk("l1_is_dr", 32'(is_dr), 0);
        chk("l1_osc", 32'(osc_phase_reset), 1);
        chk("l1_busy", 32'(busy), 1);
        for (int c = 1; c < 20; c++) begin
            cyc(0, 0, (c <= FC), 9'(c * 3), 9'(-c));
            chk("flush_filt_in", 32'(filt_in), 0);
            chk("flush_chroma_en", 32'(chroma_en), 0);
            chk("flush_osc", 32'(osc_phase_reset), 0);
        end
        for (int c = 20; c <= 40; c++) begin
            if (c < 30) exp_q.push_back(9'(100));
            cyc(0, 0, (c < 30), 9'(100), 9'(-50));
            chk("burst_filt_in", 32'(filt_in), (c < 30) ? 100 : 0);
            chk("burst_chroma_en", 32'(chroma_en), ((c + 1) >= 25 && (c + 1) <= 34) ? 1 : 0);
            chk("burst_busy", 32'(busy), ((c + 1) < 35) ? 1 : 0);
        end
        chk("burst_q_empty", exp_q.size(), 0);

        // Db/Dr alternation.
        cyc(1, 0, 0, 0, 0);
        chk("l2_is_dr", 32'(is_dr), 1);
        chk("l2_osc", 32'(osc_phase_reset), 1);
        cyc(0, 0, 0, 0, 0);
        chk("l2_osc_fall", 32'(osc_phase_reset), 0);
        chk("l2_is_dr_hold", 32'(is_dr), 1);
        cyc(1, 0, 0, 0, 0);
        chk("l3_is_dr", 32'(is_dr), 0);
        cyc(0, 0, 0, 0, 0);

        // Field start coincident with line start after a Db line.
        cyc(1, 1, 0, 0, 0);
        chk("fs_ls_is_dr", 32'(is_dr), 0);
        chk("fs_ls_osc", 32'(osc_phase_reset), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("after_fs_is_dr", 32'(is_dr), 1);
        cyc(1, 0, 0, 0, 0);
        chk("pre_fs_is_dr", 32'(is_dr), 0);

        // Field start alone: no state change, but clears the alternation.
        cyc(0, 1, 0, 0, 0);
        chk("fs_only_is_dr", 32'(is_dr), 0);
        chk("fs_only_busy", 32'(busy), 1);
        cyc(1, 0, 0, 0, 0);
        chk("fs_only_next_is_dr", 32'(is_dr), 0);

        // Dr line aborted mid-ACTIVE: only samples whose enable precedes the abort emerge.
        cyc(1, 0, 0, 0, 0);
        chk("abort_line_is_dr", 32'(is_dr), 1);
        for (int c = 1; c < 20; c++) cyc(0, 0, 0, 0, 0);
        for (int c = 20; c <= 27; c++) begin
            if (c <= 23) exp_q.push_back(9'(-c));
            cyc(0, 0, 1, 9'(77), 9'(-c));
            chk("abort_filt_in", 32'(filt_in), -c);
        end
        cyc(1, 0, 1, 9'(77), 9'(-28));
        chk("abort_chroma_en", 32'(chroma_en), 0);
        chk("abort_is_dr", 32'(is_dr), 0);
        chk("abort_osc", 32'(osc_phase_reset), 1);
        chk("abort_busy", 32'(busy), 1);
        chk("abort_filt_in_last", 32'(filt_in), -28);
        for (int c = 1; c <= 6; c++) begin
            cyc(0, 0, 1, 9'(55), 9'(-5));
            chk("abort_flush_filt_in", 32'(filt_in), 0);
            chk("abort_flush_chroma_en", 32'(chroma_en), 0);
        end
        chk("abort_q_empty", exp_q.size(), 0);

        // Reset mid-ACTIVE on a Db line.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rl_is_dr", 32'(is_dr), 0);
        for (int c = 1; c < 20; c++) cyc(0, 0, 0, 0, 0);
        for (int c = 20; c <= 26; c++) begin
            if (c <= 21) exp_q.push_back(9'(40 + c));
            cyc(0, 0, 1, 9'(40 + c), 9'(-c));
            chk("rl_filt_in", 32'(filt_in), 40 + c);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_is_dr", 32'(is_dr), 0);
        chk("arst_filt_in", 32'(filt_in), 0);
        chk("arst_chroma_en", 32'(chroma_en), 0);
        chk("arst_chroma_out", 32'(chroma_out), 0);
        chk("arst_osc", 32'(osc_phase_reset), 0);
        line_start   = 1'b0;
        active_video = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("post_rst_is_dr", 32'(is_dr), 0);
        chk("post_rst_osc", 32'(osc_phase_reset), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
